// File: rtl/mem_stage_dcache.sv
// mem_stage_dcache: direct-mapped, write-back, write-allocate data cache for
// the MEM stage. A hit answers combinationally. A miss raises busy_wait,
// optionally writes back a dirty victim, then fills the line over a 128-bit
// block interface.
//
// Handshake: mem_read / mem_write are level requests held with stable
// mem_address / mem_writedata until an edge samples mem_busywait = 0, which
// is the acceptance edge. busy_wait freezes upstream, so request inputs are
// stable while it is high.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   read, write, funct3   access request and type (B/H/W/BU/HU)
//   address, write_data   byte address and store data
//   dmem_out              extended load data (0 unless a load hits in IDLE)
//   busy_wait             pipeline stall request
//   mem_read, mem_write   block requests to main memory
//   mem_address           block address (byte address [31:4])
//   mem_writedata         victim block, word 0 in [31:0]
//   mem_readdata          fetched block, word 0 in [31:0]
//   mem_busywait          main memory still working
//   dbg_state             current FSM state (0 IDLE, 1 WRITEBACK, 2 ALLOCATE)
module mem_stage_dcache #(
    parameter int SETS = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         read,
    input  logic         write,
    input  logic [2:0]   funct3,
    input  logic [31:0]  address,
    input  logic [31:0]  write_data,
    output logic [31:0]  dmem_out,
    output logic         busy_wait,
    output logic         mem_read,
    output logic         mem_write,
    output logic [27:0]  mem_address,
    output logic [127:0] mem_writedata,
    input  logic [127:0] mem_readdata,
    input  logic         mem_busywait,
    output logic [1:0]   dbg_state
);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 28 - IDX_W;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [SETS-1:0]    valid_q, valid_d;
    logic [SETS-1:0]    dirty_q, dirty_d;
    logic [TAG_W-1:0]   tag_q  [SETS];
    logic [127:0]       data_q [SETS];

    // Single-line array update: one line is written per edge at most.
    logic               line_we;
    logic [TAG_W-1:0]   line_tag_d;
    logic [127:0]       line_data_d;

    logic [IDX_W-1:0]   idx;
    logic [TAG_W-1:0]   tag;
    logic [1:0]         word_sel;
    logic [127:0]       blk;
    logic [31:0]        word;
    logic [31:0]        new_word;
    logic [127:0]       new_blk;
    logic [7:0]         ld_byte;
    logic [15:0]        ld_half;
    logic [31:0]        ld_ext;
    logic               req;
    logic               hit;
    logic               fill;
    logic               store_hit;

    assign idx      = address[4 +: IDX_W];
    assign tag      = address[31 -: TAG_W];
    assign word_sel = address[3:2];
    assign blk      = data_q[idx];
    assign word     = blk[{word_sel, 5'b00000} +: 32];
    assign ld_byte  = word[{address[1:0], 3'b000} +: 8];
    assign ld_half  = word[{address[1], 4'b0000} +: 16];

    assign req       = read | write;
    assign hit       = valid_q[idx] && (tag_q[idx] == tag);
    assign fill      = (state_q == ALLOCATE) && !mem_busywait;
    assign store_hit = (state_q == IDLE) && write && hit;

    always_comb begin
        case (funct3)
            3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_ext = {24'd0, ld_byte};
            3'b101:  ld_ext = {16'd0, ld_half};
            default: ld_ext = word;
        endcase
    end

    // Store merge into the addressed word, then into the block.
    always_comb begin
        new_word = word;
        case (funct3)
            3'b000:  new_word[{address[1:0], 3'b000} +: 8] = write_data[7:0];
            3'b001:  new_word[{address[1], 4'b0000} +: 16] = write_data[15:0];
            default: new_word = write_data;
        endcase
        new_blk = blk;
        new_blk[{word_sel, 5'b00000} +: 32] = new_word;
    end

    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        dirty_d     = dirty_q;
        line_we     = 1'b0;
        line_tag_d  = tag_q[idx];
        line_data_d = blk;
        case (state_q)
            IDLE: begin
                if (req && !hit) begin
                    state_d = (valid_q[idx] && dirty_q[idx]) ? WRITEBACK : ALLOCATE;
                end else if (store_hit) begin
                    line_we      = 1'b1;
                    line_data_d  = new_blk;
                    dirty_d[idx] = 1'b1;
                end
            end
            WRITEBACK: begin
                if (!mem_busywait) state_d = ALLOCATE;
            end
            ALLOCATE: begin
                if (fill) begin
                    state_d      = IDLE;
                    line_we      = 1'b1;
                    line_tag_d   = tag;
                    line_data_d  = mem_readdata;
                    valid_d[idx] = 1'b1;
                    dirty_d[idx] = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Tag and data arrays are deliberately left unreset; valid gates them.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            dirty_q <= dirty_d;
            if (line_we) begin
                tag_q[idx]  <= line_tag_d;
                data_q[idx] <= line_data_d;
            end
        end
    end

    // Outputs are forced to zero while reset is held so an abandoned miss
    // drops its memory request in the reset cycle itself.
    always_comb begin
        busy_wait     = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_address   = '0;
        mem_writedata = '0;
        dmem_out      = '0;
        dbg_state     = 2'd0;
        if (!reset) begin
            dbg_state = state_q;
            busy_wait = (state_q != IDLE) || (req && !hit);
            if (state_q == WRITEBACK) begin
                mem_write     = 1'b1;
                mem_address   = {tag_q[idx], idx};
                mem_writedata = blk;
            end else if (state_q == ALLOCATE) begin
                mem_read    = 1'b1;
                mem_address = address[31:4];
            end
            if ((state_q == IDLE) && read && !write && hit) dmem_out = ld_ext;
        end
    end
endmodule

// File: tb/tb_mem_stage_dcache.sv
module tb_mem_stage_dcache;
  localparam int LAT = 5;
  localparam logic [2:0] F_B = 3'b000, F_H = 3'b001, F_W = 3'b010,
                         F_BU = 3'b100, F_HU = 3'b101;

  logic         clk;
  logic         reset;
  logic         read;
  logic         write;
  logic [2:0]   funct3;
  logic [31:0]  address;
  logic [31:0]  write_data;
  logic [31:0]  dmem_out;
  logic         busy_wait;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_address;
  logic [127:0] mem_writedata;
  logic [127:0] mem_readdata;
  logic         mem_busywait;
  logic [1:0]   dbg_state;

  mem_stage_dcache #(.SETS(8)) dut (
    .clk(clk), .reset(reset), .read(read), .write(write), .funct3(funct3),
    .address(address), .write_data(write_data), .dmem_out(dmem_out),
    .busy_wait(busy_wait), .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_writedata(mem_writedata),
    .mem_readdata(mem_readdata), .mem_busywait(mem_busywait),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  // main memory model: fixed latency, busywait low in the LAT-th request cycle
  logic [127:0] mem_arr [64];
  logic [127:0] wb_q [$];
  int           mem_cnt;
  assign mem_readdata = mem_arr[mem_address[5:0]];
  assign mem_busywait = (mem_read || mem_write) && (mem_cnt < LAT - 1);

  always @(posedge clk) begin
    if (mem_read || mem_write) begin
      if (mem_busywait) mem_cnt <= mem_cnt + 1;
      else begin
        mem_cnt <= 0;
        if (mem_write) wb_q.push_back(mem_writedata);
      end
    end else begin
      mem_cnt <= 0;
    end
  end

  // scoreboard
  int           cmp_cnt = 0;
  int           err_cnt = 0;
  logic [28:0]  exp_req_q [$];   // {is_write, block address}
  logic [31:0]  exp_load_q [$];
  int           rd_cycles = 0;
  int           wr_cycles = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // monitor: pops expected values whenever the DUT presents a response
  logic prev_rd = 1'b0;
  logic prev_wr = 1'b0;
  always @(negedge clk) begin
    if (!reset) begin
      if (mem_read || mem_write) check("mem_rw_exclusive", {mem_read, mem_write}, (mem_read ? 2'b10 : 2'b01));
      if ((mem_read && !prev_rd) || (mem_write && !prev_wr)) begin
        if (exp_req_q.size() == 0) check("unexpected_mem_req", {mem_write, mem_address}, 29'h1fff_ffff);
        else check("mem_req", {mem_write, mem_address}, exp_req_q.pop_front());
      end
      if (read && !busy_wait) begin
        if (exp_load_q.size() == 0) check("unexpected_load", dmem_out, 32'hxxxx_xxxx);
        else check("dmem_out", dmem_out, exp_load_q.pop_front());
      end
    end
    if (mem_read) rd_cycles++;
    if (mem_write) wr_cycles++;
    prev_rd = mem_read;
    prev_wr = mem_write;
  end

  // driver: called at posedge+#1; holds the request until busy_wait drops
  task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, output int stall);
    read = rd; write = wr; funct3 = f3; address = a; write_data = wd;
    stall = 0;
    @(negedge clk);
    while (busy_wait && stall < 200) begin
      stall++;
      @(negedge clk);
    end
    if (busy_wait) check("busy_timeout", 1'b1, 1'b0);
    @(posedge clk);
    #1;
    read = 1'b0; write = 1'b0;
  endtask

  task automatic load(input string name, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] exp, input int exp_stall);
    int s;
    exp_load_q.push_back(exp);
    access(1'b1, 1'b0, f3, a, 32'd0, s);
    check(name, s, exp_stall);
  endtask

  task automatic store(input string name, input logic rd, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d, input int exp_stall);
    int s;
    if (rd) exp_load_q.push_back(32'd0);
    access(rd, 1'b1, f3, a, d, s);
    check(name, s, exp_stall);
  endtask

  initial begin
    int r0, w0;
    for (int i = 0; i < 64; i++) mem_arr[i] = '0;
    mem_arr[6'h04] = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    mem_arr[6'h10] = {32'h0A0A0A0A, 32'h09090909, 32'h08080808, 32'h07070707};
    mem_arr[6'h18] = {32'h58585858, 32'h57575757, 32'h56565656, 32'h55555555};
    mem_arr[6'h20] = {32'h23232323, 32'h22222222, 32'h21212121, 32'h20202020};
    mem_arr[6'h28] = {32'h69696969, 32'h68686868, 32'h67676767, 32'h66666666};
    mem_arr[6'h30] = {32'h33333330, 32'h32323232, 32'h31313131, 32'h30303030};
    mem_arr[6'h34] = {32'h7A7A7A7A, 32'h79797979, 32'h78787878, 32'h77777777};
    mem_cnt = 0;

    // reset: outputs held at zero even with a request present
    reset = 1'b1; read = 1'b1; write = 1'b0; funct3 = F_W;
    address = 32'h40; write_data = 32'd0;
    @(negedge clk);
    check("rst_busy", busy_wait, 1'b0);
    check("rst_mem_req", {mem_read, mem_write}, 2'b00);
    check("rst_dmem_out", dmem_out, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0; read = 1'b0;
    @(negedge clk);
    check("idle_busy", busy_wait, 1'b0);
    check("idle_state", dbg_state, 2'd0);
    @(posedge clk); #1;

    // cold load miss
    r0 = rd_cycles;
    exp_req_q.push_back({1'b0, 28'h0000004});
    load("cold_miss_stall", F_W, 32'h40, 32'h11111111, LAT + 1);
    check("cold_miss_rd_cycles", rd_cycles - r0, LAT);

    // hit and extension (store fills line 0 with tag 2 first)
    exp_req_q.push_back({1'b0, 28'h0000010});
    store("sw_100_stall", 1'b0, F_W, 32'h100, 32'h800000F0, LAT + 1);
    load("lb_stall", F_B, 32'h100, 32'hFFFFFFF0, 0);
    load("lbu_stall", F_BU, 32'h100, 32'h000000F0, 0);
    load("lh_stall", F_H, 32'h102, 32'hFFFF8000, 0);
    load("lhu_stall", F_HU, 32'h102, 32'h00008000, 0);
    load("lw_other_f3", 3'b011, 32'h100, 32'h800000F0, 0);

    // store byte hit, then dirty eviction
    store("sb_101_stall", 1'b0, F_B, 32'h101, 32'h000000AB, 0);
    load("lb_101", F_BU, 32'h101, 32'h000000AB, 0);
    exp_req_q.push_back({1'b1, 28'h0000010});
    exp_req_q.push_back({1'b0, 28'h0000018});
    load("dirty_miss_stall", F_W, 32'h180, 32'h55555555, 2 * LAT + 1);
    check("wb1_count", wb_q.size(), 1);
    if (wb_q.size() > 0)
      check("wb1_data", wb_q.pop_front(), {32'h0A0A0A0A, 32'h09090909, 32'h08080808, 32'h8000ABF0});

    // store miss with clean victim
    w0 = wr_cycles;
    exp_req_q.push_back({1'b0, 28'h0000020});
    store("sw_200_stall", 1'b0, F_W, 32'h200, 32'hDEADBEEF, LAT + 1);
    check("sw_200_no_write", wr_cycles - w0, 0);
    load("lw_200", F_W, 32'h200, 32'hDEADBEEF, 0);
    exp_req_q.push_back({1'b1, 28'h0000020});
    exp_req_q.push_back({1'b0, 28'h0000028});
    load("dirty_200_evict", F_W, 32'h280, 32'h66666666, 2 * LAT + 1);
    check("wb2_count", wb_q.size(), 1);
    if (wb_q.size() > 0)
      check("wb2_data", wb_q.pop_front(), {32'h23232323, 32'h22222222, 32'h21212121, 32'hDEADBEEF});

    // reset two cycles into a fill
    r0 = rd_cycles;
    exp_req_q.push_back({1'b0, 28'h0000034});
    read = 1'b1; write = 1'b0; funct3 = F_W; address = 32'h340;
    @(posedge clk); @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; read = 1'b0;
    @(negedge clk);
    check("abort_mem_read", mem_read, 1'b0);
    check("abort_busy", busy_wait, 1'b0);
    check("abort_state", dbg_state, 2'd0);
    check("abort_rd_cycles", rd_cycles - r0, 2);
    @(posedge clk); #1;
    exp_req_q.push_back({1'b0, 28'h0000034});
    load("post_reset_miss", F_W, 32'h340, 32'h77777777, LAT + 1);

    // read and write together: treated as a store, dmem_out 0
    exp_req_q.push_back({1'b0, 28'h0000030});
    store("rw_both_stall", 1'b1, F_W, 32'h300, 32'h12345678, LAT + 1);
    load("lw_300", F_W, 32'h300, 32'h12345678, 0);

    @(posedge clk); #1;
    check("exp_req_drained", exp_req_q.size(), 0);
    check("exp_load_drained", exp_load_q.size(), 0);
    check("no_extra_wb", wb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end
endmodule

// File: doc/mem_stage_dcache.md
# mem_stage_dcache

Direct-mapped, write-back, write-allocate data cache for the MEM stage of the RV32IM pipeline. Sits between the EX/MEM pipeline register and the MEM/WB pipeline register: it takes the ALU-computed address, store data and load/store type, returns the sign/zero-extended load value as `dmem_out`, and raises `busy_wait` to freeze every pipeline register while it services a miss from main memory over a 128-bit block interface.

## Interface
- `SETS`, 8: number of cache lines; power of two, at least 2. Block size is fixed at 16 bytes (4 words).
- `clk` input 1: clock; all state updates on rising edge.
- `reset` input 1: synchronous, active-high.
- `read` input 1: load request from EX/MEM.
- `write` input 1: store request from EX/MEM.
- `funct3` input 3: access type. 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `address` input 32: byte address, from the ALU result.
- `write_data` input 32: store data, from rs2.
- `dmem_out` output 32: load result, extended per `funct3`.
- `busy_wait` output 1: stall request to all pipeline registers and the PC.
- `mem_read` output 1: block read request to main memory.
- `mem_write` output 1: block write request to main memory.
- `mem_address` output 28: block address, i.e. byte address bits [31:4].
- `mem_writedata` output 128: victim block; word 0 in bits [31:0].
- `mem_readdata` input 128: fetched block, same word ordering.
- `mem_busywait` input 1: main memory is still working on the current request.

## Operation
- Address split: offset = [3:0], where [3:2] selects the word and [1:0] the byte. Index = next log2(SETS) bits. Tag = the remaining upper bits.
- Per-line state: valid, dirty, tag, 128-bit data.
- Hit = `valid[index]` and the stored tag equals the address tag.
- Alignment: halfword accesses ignore `address[0]`; word accesses ignore `address[1:0]`. No misalignment trap.
- Load extension: B and H sign-extend; BU and HU zero-extend. Any other `funct3` on a load returns the full word.
- Stores: B writes byte lane `address[1:0]`; H writes halfword `address[1]`; W writes the whole word. Any other `funct3` writes the whole word.
- `read` and `write` both high: treated as a write; `dmem_out` = 0.
- Neither asserted: `busy_wait` = 0 and no state change.
- `dmem_out` is the hit data only while `read`, hit and IDLE all hold. Otherwise it is 0.
- FSM states: IDLE, WRITEBACK, ALLOCATE.
- IDLE:
  - Request and hit: no stall. A store updates the selected bytes and sets dirty at the next edge.
  - Request and miss: go to WRITEBACK if the victim line is valid and dirty, otherwise go to ALLOCATE.
- WRITEBACK:
  - `mem_write` = 1.
  - `mem_address` = {victim tag, index}; `mem_writedata` = victim block.
  - At an edge with `mem_busywait` = 0, go to ALLOCATE.
- ALLOCATE:
  - `mem_read` = 1; `mem_address` = `address[31:4]`.
  - At an edge with `mem_busywait` = 0, load `mem_readdata` into the line, write the tag, set valid, clear dirty, and go to IDLE.
  - The request then hits in IDLE, and any store merges on that hit.
- `mem_read` and `mem_write` are never high together, and both are 0 in IDLE.
- Upstream holds `read`, `write`, `funct3`, `address` and `write_data` stable while `busy_wait` = 1, because EX/MEM is frozen.

## Timing
- Hit: `dmem_out` and `busy_wait` = 0 are combinational in the same cycle. The MEM/WB register captures at the next edge.
- Miss: `busy_wait` rises combinationally in the cycle the miss is detected, so the edge closing that cycle is already stalled. It stays 1 through WRITEBACK and ALLOCATE.
- `busy_wait` falls in the first IDLE cycle after the fill.
- Clean miss stall: L + 1 cycles, where L = cycles from `mem_read` asserted to the edge at which `mem_busywait` is sampled low.
- Dirty miss stall: Lw + Lr + 1 cycles.
- Reset:
  - At the reset edge: all valid and dirty bits cleared, state = IDLE. Tag and data arrays are not cleared.
  - While `reset` = 1, all outputs are 0.
  - Reset mid-miss abandons the memory transaction immediately: `mem_read`/`mem_write` drop at that edge, and any in-flight dirty data is discarded.
- Memory requests are level signals, held until accepted. Address and data are stable for the whole request.

## Test plan
- Cold load miss:
  - Stimulus: after reset, LW at 0x0000_0040; memory latency 5 and block {0x44444444, 0x33333333, 0x22222222, 0x11111111} (word 3 down to word 0).
  - Required: `mem_read` high for 5 cycles with `mem_address` = 0x0000004; `busy_wait` high for 6 cycles; then `dmem_out` = 0x11111111.
- Hit and extension:
  - Stimulus: word 0x8000_00F0 cached at 0x100; then LB 0x100, LBU 0x100, LH 0x102, LHU 0x102.
  - Required: 0xFFFF_FFF0, 0x0000_00F0, 0xFFFF_8000, 0x0000_8000, each with no stall.
- Store hit then dirty eviction (SETS = 8):
  - Stimulus: SB 0xAB to 0x101; later LW 0x180, which maps to the same index with a different tag.
  - Required: first WRITEBACK with `mem_address` = 0x0000010 and byte 1 of word 0 = 0xAB; then ALLOCATE with 0x0000018.
- Store miss, clean victim:
  - Stimulus: SW 0xDEADBEEF to 0x200.
  - Required: ALLOCATE only, no `mem_write`; afterwards LW 0x200 = 0xDEADBEEF and the line is dirty.
- Reset during ALLOCATE:
  - Stimulus: assert `reset` 2 cycles into a fill.
  - Required: `mem_read` = 0 and `busy_wait` = 0 after that edge; the next access to the same address misses.
- Read and write together:
  - Stimulus: `read` = `write` = 1, SW 0x12345678 at 0x300.
  - Required: store performed and `dmem_out` = 0.
